pipe_reg_bus_reader: RTL and testbench

Sequenced reader for the shared tri-state pipeline-register bus: owns the active-high `cs` deselect lines of up to `NrOfSlots` pipeline registers and enables exactly one at a time. It samples the shared bus after a programmable settle time and hands each captured word downstream on a valid/ready handshake. It sits between the EX/MEM pipeline registers and the debug/snapshot path. It is the consumer end of those registers' Q outputs, which float to high-Z while their `cs` is 1.

---
 rtl/pipe_reg_bus_reader.sv | 148 ++++++++++++++
 tb/tb_pipe_reg_bus_reader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_bus_reader.sv
// Sequenced reader for a shared tri-state pipeline-register bus: enables one
// register at a time, samples the bus after a settle time, and streams each word out.
module pipe_reg_bus_reader #(
  parameter int NrOfBits     = 32,
  parameter int NrOfSlots    = 4,
  parameter int SettleCycles = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Tick,
  input  logic                 Start,
  input  logic [NrOfSlots-1:0] SlotMask,
  input  logic [NrOfBits-1:0]  BusIn,
  output logic [NrOfSlots-1:0] cs,
  input  logic                 Ready,
  output logic                 Valid,
  output logic [NrOfBits-1:0]  Data,
  output logic [3:0]           SlotIdx,
  output logic                 Busy,
  output logic                 Done
);

  // Handshake: a word moves downstream on any clock edge where Valid and Ready
  // are both 1; while Valid=1 and Ready=0, Data and SlotIdx do not change, and
  // Ready may be raised before Valid.

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SELECT   = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE = 4'(SettleCycles);

  // state is the observable FSM state for bound checkers.
  state_t                state, state_d;
  logic [NrOfSlots-1:0] mask_q, mask_d;
  logic [3:0]           slot_q, slot_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 valid_d;
  logic [NrOfBits-1:0]  data_d;
  logic [3:0]           idx_d;

  function automatic logic [3:0] lowest_slot(input logic [NrOfSlots-1:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = NrOfSlots - 1; i >= 0; i--) begin
      if (m[i]) r = 4'(i);
    end
    return r;
  endfunction

  function automatic logic [NrOfSlots-1:0] slot_bit(input logic [3:0] s);
    logic [NrOfSlots-1:0] b;
    b = '0;
    for (int i = 0; i < NrOfSlots; i++) begin
      b[i] = (4'(i) == s);
    end
    return b;
  endfunction

  always_comb begin
    state_d = state;
    mask_d  = mask_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    valid_d = Valid;
    data_d  = Data;
    idx_d   = SlotIdx;

    case (state)
      S_IDLE: begin
        if (Tick && Start) begin
          mask_d = SlotMask;
          if (SlotMask == '0) begin
            state_d = S_DONE;
          end else begin
            slot_d  = lowest_slot(SlotMask);
            cnt_d   = SETTLE;
            state_d = S_SELECT;
          end
        end
      end
      S_SELECT: begin
        if (Tick) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            data_d  = BusIn;
            idx_d   = slot_q;
            valid_d = 1'b1;
            mask_d  = mask_q & ~slot_bit(slot_q);
            state_d = S_WAIT_ACK;
          end
        end
      end
      S_WAIT_ACK: begin
        if (Valid && Ready) begin
          valid_d = 1'b0;
          if (mask_q != '0) begin
            slot_d  = lowest_slot(mask_q);
            cnt_d   = SETTLE;
            state_d = S_SELECT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // cs decodes from registered state only, so exactly one slot drives the bus
  // in SELECT and none does anywhere else.
  always_comb begin
    cs   = '1;
    Busy = (state != S_IDLE);
    Done = (state == S_DONE);
    if (state == S_SELECT) cs = ~slot_bit(slot_q);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= S_IDLE;
      mask_q  <= '0;
      slot_q  <= '0;
      cnt_q   <= '0;
      Valid   <= 1'b0;
      Data    <= '0;
      SlotIdx <= '0;
    end else begin
      state   <= state_d;
      mask_q  <= mask_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      Valid   <= valid_d;
      Data    <= data_d;
      SlotIdx <= idx_d;
    end
  end

endmodule

// File: tb/tb_pipe_reg_bus_reader.sv
// Directed bench for pipe_reg_bus_reader: one instance with a 1-cycle settle,
// one with a 2-cycle settle for Tick gating; bus modelled from the cs lines.
module tb_pipe_reg_bus_reader;

  localparam int W = 32;
  localparam int N = 4;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Tick, Start, Ready;
  logic [N-1:0] SlotMask;
  logic [W-1:0] BusIn;
  logic [N-1:0] cs;
  logic         Valid, Busy, Done;
  logic [W-1:0] Data;
  logic [3:0]   SlotIdx;

  logic         Tick_b, Start_b, Ready_b;
  logic [N-1:0] SlotMask_b;
  logic [W-1:0] BusIn_b;
  logic [N-1:0] cs_b;
  logic         Valid_b, Busy_b, Done_b;
  logic [W-1:0] Data_b;
  logic [3:0]   SlotIdx_b;

  logic [W-1:0] regs [N];
  logic [W-1:0] bias;

  int vectors    = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_idx_q[$];

  always #5 Clock = ~Clock;

  pipe_reg_bus_reader #(.NrOfBits(W), .NrOfSlots(N), .SettleCycles(1)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Start(Start), .SlotMask(SlotMask),
    .BusIn(BusIn), .cs(cs), .Ready(Ready), .Valid(Valid), .Data(Data),
    .SlotIdx(SlotIdx), .Busy(Busy), .Done(Done)
  );

  pipe_reg_bus_reader #(.NrOfBits(W), .NrOfSlots(N), .SettleCycles(2)) dut_b (
    .Clock(Clock), .Reset(Reset), .Tick(Tick_b), .Start(Start_b), .SlotMask(SlotMask_b),
    .BusIn(BusIn_b), .cs(cs_b), .Ready(Ready_b), .Valid(Valid_b), .Data(Data_b),
    .SlotIdx(SlotIdx_b), .Busy(Busy_b), .Done(Done_b)
  );

  // Register k drives regs[k]+bias only while its cs is low; otherwise the bus floats.
  always_comb begin
    BusIn = 32'hDEAD_BEEF;
    for (int k = 0; k < N; k++) if (!cs[k]) BusIn = regs[k] + bias;
  end

  always_comb begin
    BusIn_b = 32'hDEAD_BEEF;
    for (int k = 0; k < N; k++) if (!cs_b[k]) BusIn_b = regs[k] + bias;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #500000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int  zeros;
    int  ticks;
    logic [W-1:0] last_bias;
    logic got, done_seen;
    logic [N-1:0] m;

    Reset = 1'b1; Tick = 1'b1; Start = 1'b0; Ready = 1'b1; SlotMask = '0;
    Tick_b = 1'b0; Start_b = 1'b0; Ready_b = 1'b1; SlotMask_b = '0;
    bias = '0;
    for (int k = 0; k < N; k++) regs[k] = 32'hA0 + 32'(k);

    // Reset state
    repeat (2) step();
    chk("rst_cs", 64'(cs), 64'hF);
    chk("rst_valid", 64'(Valid), 64'h0);
    chk("rst_data", 64'(Data), 64'h0);
    chk("rst_idx", 64'(SlotIdx), 64'h0);
    chk("rst_busy", 64'(Busy), 64'h0);
    chk("rst_done", 64'(Done), 64'h0);
    chk("rst_b_cs", 64'(cs_b), 64'hF);
    Reset = 1'b0;
    step();

    // Basic scan, mask 0101
    SlotMask = 4'b0101; Start = 1'b1;
    step(); Start = 1'b0;
    chk("basic_cs1", 64'(cs), 64'hE);
    chk("basic_busy", 64'(Busy), 64'h1);
    step(); chk("basic_cs2", 64'(cs), 64'hE);
    step(); chk("basic_cs3", 64'(cs), 64'hF);
    chk("basic_valid0", 64'(Valid), 64'h1);
    chk("basic_data0", 64'(Data), 64'hA0);
    chk("basic_idx0", 64'(SlotIdx), 64'h0);
    step(); chk("basic_cs4", 64'(cs), 64'hB);
    chk("basic_valid_drop", 64'(Valid), 64'h0);
    step(); chk("basic_cs5", 64'(cs), 64'hB);
    step(); chk("basic_cs6", 64'(cs), 64'hF);
    chk("basic_data2", 64'(Data), 64'hA2);
    chk("basic_idx2", 64'(SlotIdx), 64'h2);
    chk("basic_nodone", 64'(Done), 64'h0);
    step(); chk("basic_done", 64'(Done), 64'h1);
    chk("basic_busy_done", 64'(Busy), 64'h1);
    step(); chk("basic_done_off", 64'(Done), 64'h0);
    chk("basic_idle", 64'(Busy), 64'h0);

    // Backpressure, mask 0010
    regs[1] = 32'h11; Ready = 1'b0;
    SlotMask = 4'b0010; Start = 1'b1;
    step(); Start = 1'b0;
    chk("bp_cs", 64'(cs), 64'hD);
    step(); step();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 64'(Valid), 64'h1);
      chk("bp_data", 64'(Data), 64'h11);
      chk("bp_idx", 64'(SlotIdx), 64'h1);
      chk("bp_cs_hold", 64'(cs), 64'hF);
      regs[1] = 32'h77 + 32'(c);
      if (c < 4) step();
    end
    Ready = 1'b1;
    step(); chk("bp_valid_off", 64'(Valid), 64'h0);
    chk("bp_done", 64'(Done), 64'h1);
    step(); chk("bp_idle", 64'(Busy), 64'h0);
    regs[1] = 32'hA1;

    // Empty mask
    SlotMask = 4'b0000; Start = 1'b1;
    step(); Start = 1'b0;
    chk("empty_done", 64'(Done), 64'h1);
    chk("empty_cs", 64'(cs), 64'hF);
    step(); chk("empty_done_off", 64'(Done), 64'h0);
    chk("empty_idle", 64'(Busy), 64'h0);
    chk("empty_cs2", 64'(cs), 64'hF);

    // Start held high and mask changed during a scan
    SlotMask = 4'b0011; Start = 1'b1;
    step(); SlotMask = 4'b1100;
    chk("sb_cs1", 64'(cs), 64'hE);
    step(); step();
    chk("sb_idx0", 64'(SlotIdx), 64'h0);
    chk("sb_data0", 64'(Data), 64'hA0);
    step(); chk("sb_cs2", 64'(cs), 64'hD);
    step(); step();
    chk("sb_idx1", 64'(SlotIdx), 64'h1);
    chk("sb_data1", 64'(Data), 64'hA1);
    step(); chk("sb_done", 64'(Done), 64'h1);
    Start = 1'b0;
    step(); chk("sb_idle", 64'(Busy), 64'h0);

    // Reset mid-SELECT of slot 1, with a coincident Start
    SlotMask = 4'b1111; Start = 1'b1;
    step(); Start = 1'b0;
    step(); step(); step();
    chk("rm_cs_slot1", 64'(cs), 64'hD);
    Reset = 1'b1; Start = 1'b1;
    step(); Reset = 1'b0; Start = 1'b0;
    chk("rm_cs", 64'(cs), 64'hF);
    chk("rm_valid", 64'(Valid), 64'h0);
    chk("rm_busy", 64'(Busy), 64'h0);
    chk("rm_done", 64'(Done), 64'h0);
    for (int c = 0; c < 3; c++) begin
      step(); chk("rm_no_done", 64'(Done), 64'h0);
    end
    SlotMask = 4'b1000; Start = 1'b1;
    step(); Start = 1'b0;
    chk("rm2_cs", 64'(cs), 64'h7);
    step(); step();
    chk("rm2_idx", 64'(SlotIdx), 64'h3);
    chk("rm2_data", 64'(Data), 64'hA3);
    step(); chk("rm2_done", 64'(Done), 64'h1);
    step();

    // Tick gating on the 2-cycle-settle instance: Tick every 3rd cycle
    regs[1] = 32'h5500;
    SlotMask_b = 4'b0010; Start_b = 1'b1;
    ticks = 0; last_bias = '0; got = 1'b0; done_seen = 1'b0;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      Tick_b = (c % 3 == 2);
      bias = 32'(c);
      if (Busy_b) Start_b = 1'b0;
      if (!cs_b[1] && Tick_b) begin
        ticks++;
        last_bias = bias;
      end
      if (Valid_b && !got) begin
        chk("tick_span", 64'(ticks), 64'h3);
        chk("tick_data", 64'(Data_b), 64'(32'h5500 + last_bias));
        chk("tick_idx", 64'(SlotIdx_b), 64'h1);
        got = 1'b1;
      end
      if (Done_b) done_seen = 1'b1;
      else step();
    end
    chk("tick_got", 64'(got), 64'h1);
    chk("tick_done", 64'(done_seen), 64'h1);
    Tick_b = 1'b0; bias = '0;
    step();

    // Random-mask scans with random Ready: cs one-hot and ascending order
    for (int r = 0; r < 4; r++) begin
      m = 4'($urandom_range(1, 15));
      for (int k = 0; k < N; k++) begin
        regs[k] = $urandom;
        if (m[k]) begin
          exp_q.push_back(regs[k]);
          exp_idx_q.push_back(4'(k));
        end
      end
      SlotMask = m; Start = 1'b1;
      step(); Start = 1'b0;
      done_seen = 1'b0;
      for (int c = 0; c < 200 && !done_seen; c++) begin
        zeros = 0;
        for (int k = 0; k < N; k++) if (!cs[k]) zeros++;
        chk("cs_onehot", 64'(zeros <= 1), 64'h1);
        if (Done) begin
          done_seen = 1'b1;
        end else begin
          Ready = 1'($urandom_range(0, 1));
          if (Valid && Ready) begin
            if (exp_q.size() == 0) begin
              chk("rnd_extra_word", 64'(1), 64'h0);
            end else begin
              chk("rnd_idx", 64'(SlotIdx), 64'(exp_idx_q.pop_front()));
              chk("rnd_data", 64'(Data), 64'(exp_q.pop_front()));
            end
          end
          step();
        end
      end
      chk("rnd_done", 64'(done_seen), 64'h1);
      chk("rnd_q_empty", 64'(exp_q.size()), 64'h0);
      exp_q.delete();
      exp_idx_q.delete();
      Ready = 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
